// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with runtime baud divisor.
// One bit period is (baud_rate+1) clk cycles. The start bit is validated at its
// midpoint, and every later bit is sampled one full period after the previous
// sample. This places each sample near the middle of its bit.
// Optional feature macro: UART_RX_OVERRUN_EN adds a sticky overrun flag.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic [15:0] baud_rate,
  input  logic        clr_rdy,
  output logic [7:0]  rx_data,
  output logic        rdy,
  output logic        frm_err
`ifdef UART_RX_OVERRUN_EN
  ,
  output logic        overrun
`endif
);

  typedef enum logic [1:0] {IDLE, START, RECV} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s, rx_prev, fall;
  logic [15:0]            baud_cnt;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic                   cnt_clr, start_ok, sample, done;

  assign rx_s = sync[SYNC_STAGES-1];
  assign fall = rx_prev & ~rx_s;

  // RX metastability synchronizer plus the edge-detect history flop; both idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], RX};
      rx_prev <= rx_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    start_ok  = 1'b0;
    sample    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          cnt_clr   = 1'b1;
        end
      end
      START: begin
        // The start bit must still be low at its midpoint; otherwise treat it as a glitch.
        if (baud_cnt == {1'b0, baud_rate[15:1]}) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = RECV;
            start_ok  = 1'b1;
          end
        end
      end
      RECV: begin
        if (baud_cnt == baud_rate) begin
          cnt_clr = 1'b1;
          sample  = 1'b1;
          if (bit_cnt == 4'd8) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-period counter, bit index and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (cnt_clr)             baud_cnt <= '0;
      else if (state != IDLE)  baud_cnt <= baud_cnt + 16'd1;
      if (start_ok)            bit_cnt  <= '0;
      else if (sample)         bit_cnt  <= bit_cnt + 4'd1;
      if (sample && bit_cnt < 4'd8) shift_reg <= {rx_s, shift_reg[7:1]};
    end
  end

  // Output registers: byte and framing status update on the stop-bit sample.
  // A new completion takes priority over a simultaneous acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= 8'h00;
      frm_err <= 1'b0;
      rdy     <= 1'b0;
    end else begin
      if (done) begin
        rx_data <= shift_reg;
        frm_err <= ~rx_s;
      end
      if (done)         rdy <= 1'b1;
      else if (clr_rdy) rdy <= 1'b0;
    end
  end

`ifdef UART_RX_OVERRUN_EN
  // Overrun: a byte lands while the previous one is still unacknowledged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       overrun <= 1'b0;
    else if (done && rdy && !clr_rdy) overrun <= 1'b1;
    else if (clr_rdy)                 overrun <= 1'b0;
  end
`endif

endmodule
